mdu_iter: RTL and testbench

- Iterative multiply/divide unit implementing ALU unit 11: MULT, MULTU, DIV, DIVU.
- Width is parametrised; the unit is multi-cycle, with a start/busy/done handshake and HI/LO result registers.
- Sits beside the combinational ALU in EX. The pipeline stalls on busy and reads hi/lo after done.
- MTHI/MTLO write ports allow direct writes to HI/LO.

---
 rtl/mdu_pkg.sv | 25 ++
 rtl/mdu_if.sv | 31 +++
 rtl/mdu_step.sv | 40 ++++
 rtl/mdu_iter.sv | 174 +++++++++++++++++
 tb/tb_mdu_iter.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// mdu_iter shared types: func codes, FSM states, ALU unit prefix.
// Imported by the top and interface users with import mdu_pkg::*.
package mdu_pkg;

  localparam logic [1:0] UNIT_MD = 2'b11;

  typedef enum logic [1:0] {
    F_MULT  = 2'b00,
    F_MULTU = 2'b01,
    F_DIV   = 2'b10,
    F_DIVU  = 2'b11
  } func_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  function automatic logic is_div(input logic [1:0] f);
    return f[1];
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Request/result bundle between EX and the iterative MDU.
// master drives requests and MTHI/MTLO; slave is the MDU.
interface mdu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             cancel;
  logic [1:0]       func;
  logic [WIDTH-1:0] dataa;
  logic [WIDTH-1:0] datab;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             overflow;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, cancel, func, dataa, datab,
    output hi_we, lo_we, wdata,
    input  busy, done, overflow, hi, lo
  );

  modport slave (
    input  start, cancel, func, dataa, datab,
    input  hi_we, lo_we, wdata,
    output busy, done, overflow, hi, lo
  );
endinterface

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply or
// restoring compare-subtract-shift divide on {hi,lo}.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic               div_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  assign sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
                + {1'b0, b_i};
  assign rem_sh = {acc_i[2*WIDTH-1:WIDTH],
                   acc_i[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, b_i};

  // Quotient bits shift into lo as dividend bits leave it.
  always_comb begin
    acc_o = acc_i;
    unique case (1'b1)
      div_i && !diff[WIDTH]:
        acc_o = {diff[WIDTH-1:0],
                 acc_i[WIDTH-2:0], 1'b1};
      div_i && diff[WIDTH]:
        acc_o = {rem_sh[WIDTH-1:0],
                 acc_i[WIDTH-2:0], 1'b0};
      !div_i && acc_i[0]:
        acc_o = {sum, acc_i[WIDTH-1:1]};
      !div_i && !acc_i[0]:
        acc_o = {1'b0, acc_i[2*WIDTH-1:1]};
      default: acc_o = acc_i;
    endcase
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Define MDU_FAST_MULT_EN for a single-cycle multiply path.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic clk,
  input  logic clrn,
  mdu_if.slave bus
);

  localparam int W2 = 2 * WIDTH;

  state_e           state_q, state_d;
  func_e            op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [W2-1:0]    step_acc, fix_acc;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             negp_q, negp_d;
  logic             negr_q, negr_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic             req_div, req_sgn, b_zero;
  logic             op_div;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign req_div = is_div(bus.func);
  assign req_sgn = ~bus.func[0];
  assign b_zero  = (bus.datab == '0);
  assign op_div  = (op_q == F_DIV) || (op_q == F_DIVU);

  assign mag_a = (req_sgn && bus.dataa[WIDTH-1])
               ? -bus.dataa : bus.dataa;
  assign mag_b = (req_sgn && bus.datab[WIDTH-1])
               ? -bus.datab : bus.datab;

`ifdef MDU_FAST_MULT_EN
  logic [W2-1:0] ext_a, ext_b, fast_p;
  assign ext_a = {{WIDTH{req_sgn & bus.dataa[WIDTH-1]}},
                  bus.dataa};
  assign ext_b = {{WIDTH{req_sgn & bus.datab[WIDTH-1]}},
                  bus.datab};
  // Sign-extended operands give the right low 2W bits
  // for both signed and unsigned products.
  assign fast_p = ext_a * ext_b;
`endif

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .div_i (op_div),
    .acc_i (acc_q),
    .b_i   (b_q),
    .acc_o (step_acc)
  );

  always_comb begin
    fix_acc = acc_q;
    if (!op_div) begin
      if (negp_q) fix_acc = -acc_q;
    end else begin
      if (negp_q)
        fix_acc[WIDTH-1:0] = -acc_q[WIDTH-1:0];
      if (negr_q)
        fix_acc[W2-1:WIDTH] = -acc_q[W2-1:WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    b_d     = b_q;
    negp_d  = negp_q;
    negr_d  = negr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    if (bus.cancel) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.hi_we) hi_d = bus.wdata;
          if (bus.lo_we) lo_d = bus.wdata;
          if (bus.start) begin
            op_d    = func_e'(bus.func);
            b_d     = mag_b;
            ovf_d   = 1'b0;
            negp_d  = req_sgn & (bus.dataa[WIDTH-1]
                               ^ bus.datab[WIDTH-1]);
            negr_d  = req_sgn & req_div
                    & bus.dataa[WIDTH-1];
            cnt_d   = CNT_W'(WIDTH);
            acc_d   = {{WIDTH{1'b0}}, mag_a};
            state_d = S_CALC;
            // Divide by zero: raw dividend, no sign fix.
            if (req_div && b_zero) begin
              acc_d   = {bus.dataa, {WIDTH{1'b1}}};
              ovf_d   = 1'b1;
              negp_d  = 1'b0;
              negr_d  = 1'b0;
              state_d = S_FIX;
            end
`ifdef MDU_FAST_MULT_EN
            else if (!req_div) begin
              acc_d   = fast_p;
              state_d = S_DONE;
            end
`endif
          end
        end
        S_CALC: begin
          acc_d = step_acc;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = S_FIX;
        end
        S_FIX: begin
          acc_d   = fix_acc;
          state_d = S_DONE;
        end
        S_DONE: begin
          hi_d    = acc_q[W2-1:WIDTH];
          lo_d    = acc_q[WIDTH-1:0];
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= S_IDLE;
      op_q    <= F_MULT;
      cnt_q   <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      negp_q  <= 1'b0;
      negr_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      negp_q  <= negp_d;
      negr_q  <= negr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy     = (state_q == S_CALC)
                     || (state_q == S_FIX);
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter, WIDTH=32.
// Latency counted in clock edges after the start edge.
module tb_mdu_iter;

  localparam logic [1:0] MULT  = 2'b00;
  localparam logic [1:0] MULTU = 2'b01;
  localparam logic [1:0] DIV   = 2'b10;
  localparam logic [1:0] DIVU  = 2'b11;
`ifdef MDU_FAST_MULT_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;

  logic clk = 1'b0;
  logic clrn = 1'b0;
  int n_chk = 0;
  int n_err = 0;

  mdu_if #(.WIDTH(32)) bus ();

  mdu_iter #(.WIDTH(32)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    bus.hi_we  = 1'b0;
    bus.lo_we  = 1'b0;
  endtask

  task automatic run_op(string tag, logic [1:0] f,
                        logic [31:0] a, logic [31:0] b,
                        int lat, logic [31:0] eh,
                        logic [31:0] el, logic eo);
    int n;
    logic b1;
    bus.func  = f;
    bus.dataa = a;
    bus.datab = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n  = 0;
    b1 = 1'b0;
    while (!bus.done && n < 60) begin
      tick();
      n++;
      if (n == 1) b1 = bus.busy;
    end
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    chk({tag, "_busy1"}, 64'(b1), 64'(lat > 2));
    chk({tag, "_hi"}, 64'(bus.hi), 64'(eh));
    chk({tag, "_lo"}, 64'(bus.lo), 64'(el));
    chk({tag, "_ovf"}, 64'(bus.overflow), 64'(eo));
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    tick();
    chk({tag, "_pulse"}, 64'(bus.done), 64'd0);
  endtask

  task automatic count_done(int cycles, output int nd);
    nd = 0;
    repeat (cycles) begin
      tick();
      if (bus.done) nd++;
    end
  endtask

  initial begin
    int n, nd;
    idle_in();
    bus.func  = MULT;
    bus.dataa = '0;
    bus.datab = '0;
    bus.wdata = '0;
    #12;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_ovf", 64'(bus.overflow), 64'd0);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    clrn = 1'b1;
    tick();

    run_op("mult_neg", MULT, 32'hFFFFFFFD, 32'h5,
           MUL_LAT, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    run_op("multu_max", MULTU, 32'hFFFFFFFF,
           32'hFFFFFFFF, MUL_LAT, 32'hFFFFFFFE,
           32'h00000001, 1'b0);
    run_op("div_neg", DIV, 32'hFFFFFFF9, 32'h2,
           DIV_LAT, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("divu_7_2", DIVU, 32'h7, 32'h2,
           DIV_LAT, 32'h1, 32'h3, 1'b0);
    run_op("divu_z", DIVU, 32'h5, 32'h0,
           2, 32'h5, 32'hFFFFFFFF, 1'b1);
    run_op("div_min", DIV, 32'h80000000,
           32'hFFFFFFFF, DIV_LAT, 32'h0,
           32'h80000000, 1'b0);
    run_op("div_negb", DIV, 32'h7, 32'hFFFFFFFE,
           DIV_LAT, 32'h1, 32'hFFFFFFFD, 1'b0);
    run_op("div_z", DIV, 32'hFFFFFFF9, 32'h0,
           2, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1);
    run_op("multu_sh", MULTU, 32'h12345678,
           32'h100, MUL_LAT, 32'h00000012,
           32'h34567800, 1'b0);
    run_op("mult_3_5", MULT, 32'h3, 32'h5,
           MUL_LAT, 32'h0, 32'hF, 1'b0);

    bus.hi_we = 1'b1;
    bus.wdata = 32'hCAFEF00D;
    tick();
    bus.hi_we = 1'b0;
    chk("mthi", 64'(bus.hi), 64'hCAFEF00D);
    bus.lo_we = 1'b1;
    bus.wdata = 32'h12345678;
    tick();
    bus.lo_we = 1'b0;
    chk("mtlo", 64'(bus.lo), 64'h12345678);

    // DIVU 100/7 with MTHI on the start edge and a
    // second start plus MTLO while busy.
    bus.func  = DIVU;
    bus.dataa = 32'd100;
    bus.datab = 32'd7;
    bus.start = 1'b1;
    bus.hi_we = 1'b1;
    bus.wdata = 32'h55;
    tick();
    idle_in();
    chk("mthi_start", 64'(bus.hi), 64'h55);
    tick();
    tick();
    bus.start = 1'b1;
    bus.func  = MULTU;
    bus.dataa = 32'h3;
    bus.datab = 32'h5;
    bus.lo_we = 1'b1;
    bus.wdata = 32'h66;
    tick();
    idle_in();
    chk("mtlo_busy", 64'(bus.lo), 64'h12345678);
    chk("restart_busy", 64'(bus.busy), 64'd1);
    n = 3;
    while (!bus.done && n < 60) begin
      tick();
      n++;
    end
    chk("restart_lat", 64'(n), 64'(DIV_LAT));
    chk("restart_hi", 64'(bus.hi), 64'h2);
    chk("restart_lo", 64'(bus.lo), 64'hE);
    tick();

    bus.func  = DIVU;
    bus.dataa = 32'd1000;
    bus.datab = 32'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    chk("cancel_pre", 64'(bus.busy), 64'd1);
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    chk("cancel_busy", 64'(bus.busy), 64'd0);
    count_done(40, nd);
    chk("cancel_done", 64'(nd), 64'd0);
    chk("cancel_hi", 64'(bus.hi), 64'h2);
    chk("cancel_lo", 64'(bus.lo), 64'hE);

    bus.start  = 1'b1;
    bus.cancel = 1'b1;
    tick();
    idle_in();
    chk("cstart_busy", 64'(bus.busy), 64'd0);
    count_done(40, nd);
    chk("cstart_done", 64'(nd), 64'd0);

    bus.func  = DIV;
    bus.dataa = 32'd100;
    bus.datab = 32'd7;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    #2;
    clrn = 1'b0;
    #1;
    chk("rstmid_hi", 64'(bus.hi), 64'd0);
    chk("rstmid_lo", 64'(bus.lo), 64'd0);
    chk("rstmid_busy", 64'(bus.busy), 64'd0);
    tick();
    clrn = 1'b1;
    count_done(40, nd);
    chk("rstmid_done", 64'(nd), 64'd0);
    chk("rstmid_idle", 64'(bus.busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
